// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - single-port RAM arbiter shared by the Fetch and Memory-stage requesters
module mem_controller #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_req,
    input  logic [ADDR_W-1:0] if_mc_addr,
    output logic              mc_if_ack,
    output logic [DATA_W-1:0] mc_if_data,
    input  logic              mem_mc_req,
    input  logic              mem_mc_rw,
    input  logic [ADDR_W-1:0] mem_mc_addr,
    input  logic [DATA_W-1:0] mem_mc_wdata,
    output logic              mc_mem_ack,
    output logic [DATA_W-1:0] mc_mem_data,
    output logic              mc_ram_en,
    output logic              mc_ram_we,
    output logic [ADDR_W-1:0] mc_ram_addr,
    output logic [DATA_W-1:0] mc_ram_wdata,
    input  logic [DATA_W-1:0] ram_mc_rdata,
    input  logic              ram_mc_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       if_want;
    logic       mem_want;
    logic       grant_mem;
    logic       grant_if;

    // A requester being acked this cycle still holds req; mask it so it is not re-served.
    always_comb begin
        if_want   = if_mc_req && !mc_if_ack;
        mem_want  = mem_mc_req && !mc_mem_ack;
        grant_mem = mem_want && !(if_want && (starve_cnt == STARVE_LIM));
        grant_if  = if_want && !grant_mem;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            mc_if_ack    <= 1'b0;
            mc_if_data   <= '0;
            mc_mem_ack   <= 1'b0;
            mc_mem_data  <= '0;
            mc_ram_en    <= 1'b0;
            mc_ram_we    <= 1'b0;
            mc_ram_addr  <= '0;
            mc_ram_wdata <= '0;
        end else begin
            mc_if_ack  <= 1'b0;
            mc_mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state        <= BUSY_MEM;
                        mc_ram_en    <= 1'b1;
                        mc_ram_we    <= mem_mc_rw;
                        mc_ram_addr  <= mem_mc_addr;
                        mc_ram_wdata <= mem_mc_wdata;
                        if (!if_want) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_if) begin
                        state        <= BUSY_IF;
                        mc_ram_en    <= 1'b1;
                        mc_ram_we    <= 1'b0;
                        mc_ram_addr  <= if_mc_addr;
                        mc_ram_wdata <= '0;
                        starve_cnt   <= '0;
                    end
                end
                BUSY_IF: begin
                    if (ram_mc_ready) begin
                        state      <= IDLE;
                        mc_ram_en  <= 1'b0;
                        mc_ram_we  <= 1'b0;
                        mc_if_ack  <= 1'b1;
                        mc_if_data <= ram_mc_rdata;
                    end
                end
                BUSY_MEM: begin
                    if (ram_mc_ready) begin
                        state      <= IDLE;
                        mc_ram_en  <= 1'b0;
                        mc_ram_we  <= 1'b0;
                        mc_mem_ack <= 1'b1;
                        if (!mc_ram_we) begin
                            mc_mem_data <= ram_mc_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - scoreboard bench for mem_controller with a behavioural variable-latency RAM
`timescale 1ns/1ps
module tb_mem_controller;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_mc_req = 1'b0;
    logic [AW-1:0] if_mc_addr = '0;
    logic          mc_if_ack;
    logic [DW-1:0] mc_if_data;
    logic          mem_mc_req = 1'b0;
    logic          mem_mc_rw = 1'b0;
    logic [AW-1:0] mem_mc_addr = '0;
    logic [DW-1:0] mem_mc_wdata = '0;
    logic          mc_mem_ack;
    logic [DW-1:0] mc_mem_data;
    logic          mc_ram_en;
    logic          mc_ram_we;
    logic [AW-1:0] mc_ram_addr;
    logic [DW-1:0] mc_ram_wdata;
    logic [DW-1:0] ram_mc_rdata = '0;
    logic          ram_mc_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mem_controller #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .if_mc_req(if_mc_req), .if_mc_addr(if_mc_addr),
        .mc_if_ack(mc_if_ack), .mc_if_data(mc_if_data),
        .mem_mc_req(mem_mc_req), .mem_mc_rw(mem_mc_rw), .mem_mc_addr(mem_mc_addr),
        .mem_mc_wdata(mem_mc_wdata), .mc_mem_ack(mc_mem_ack), .mc_mem_data(mc_mem_data),
        .mc_ram_en(mc_ram_en), .mc_ram_we(mc_ram_we), .mc_ram_addr(mc_ram_addr),
        .mc_ram_wdata(mc_ram_wdata), .ram_mc_rdata(ram_mc_rdata), .ram_mc_ready(ram_mc_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // RAM: ready pulses in the ram_lat-th cycle that mc_ram_en is high
    int            ram_lat = 1;
    int            ram_cnt = 0;
    logic          stray = 1'b0;
    logic [DW-1:0] ram_mem [logic [AW-1:0]];

    always @(posedge clock) begin
        #1;
        ram_mc_ready = 1'b0;
        ram_mc_rdata = 32'hBAD0_BAD0;
        if (mc_ram_en) begin
            ram_cnt++;
            if (ram_cnt == ram_lat) begin
                ram_mc_ready = 1'b1;
                if (mc_ram_we) ram_mem[mc_ram_addr] = mc_ram_wdata;
                else ram_mc_rdata = ram_mem.exists(mc_ram_addr) ? ram_mem[mc_ram_addr] : pat(mc_ram_addr);
            end
        end else begin
            ram_cnt = 0;
            if (stray) begin
                ram_mc_ready = 1'b1;
                stray = 1'b0;
            end
        end
    end

    logic [DW-1:0] exp_if_q[$];
    logic [DW:0]   exp_mem_q[$];
    logic [DW-1:0] held_mem = '0;
    logic [DW-1:0] mon_e;
    logic [DW:0]   mon_m;
    int            if_acks = 0;
    int            mem_acks = 0;
    int            last_if_ack = -1;
    int            last_mem_ack = -1;
    int            en_run = 0;
    int            last_run = 0;
    logic          en_q = 1'b0;
    logic [AW-1:0] g_addr[$];
    logic          g_we[$];
    logic [DW-1:0] g_wdata[$];
    int            g_cyc[$];

    always @(negedge clock) begin
        if (mc_ram_en && !en_q) begin
            g_addr.push_back(mc_ram_addr);
            g_we.push_back(mc_ram_we);
            g_wdata.push_back(mc_ram_wdata);
            g_cyc.push_back(cyc);
        end
        if (mc_ram_en) en_run++;
        else if (en_q) begin
            last_run = en_run;
            en_run = 0;
        end
        en_q = mc_ram_en;
        if (mc_if_ack) begin
            if_acks++;
            last_if_ack = cyc;
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("FAIL if_ack_unexpected got ack data=%h want no ack", mc_if_data);
            end else begin
                mon_e = exp_if_q.pop_front();
                if (mc_if_data !== mon_e) begin
                    errors++;
                    $display("FAIL if_data got=%h want=%h", mc_if_data, mon_e);
                end
            end
        end
        if (mc_mem_ack) begin
            mem_acks++;
            last_mem_ack = cyc;
            checks++;
            if (exp_mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_ack_unexpected got ack data=%h want no ack", mc_mem_data);
            end else begin
                mon_m = exp_mem_q.pop_front();
                if (!mon_m[DW]) held_mem = mon_m[DW-1:0];
                if (mc_mem_data !== held_mem) begin
                    errors++;
                    $display("FAIL mem_data rw=%0b got=%h want=%h", mon_m[DW], mc_mem_data, held_mem);
                end
            end
        end
    end

    task automatic do_if(input logic [AW-1:0] a, input logic [DW-1:0] e);
        int n;
        if_mc_addr = a;
        if_mc_req  = 1'b1;
        exp_if_q.push_back(e);
        n = 0;
        do begin @(negedge clock); n++; end while (mc_if_ack !== 1'b1 && n < 50);
        checks++;
        if (mc_if_ack !== 1'b1) begin
            errors++;
            $display("FAIL if_ack_timeout addr=%h got=0 want=1", a);
        end
        if_mc_req = 1'b0;
    endtask

    task automatic do_mem(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] e);
        int n;
        mem_mc_rw    = rw;
        mem_mc_addr  = a;
        mem_mc_wdata = wd;
        mem_mc_req   = 1'b1;
        exp_mem_q.push_back({rw, e});
        n = 0;
        do begin @(negedge clock); n++; end while (mc_mem_ack !== 1'b1 && n < 50);
        checks++;
        if (mc_mem_ack !== 1'b1) begin
            errors++;
            $display("FAIL mem_ack_timeout addr=%h got=0 want=1", a);
        end
        mem_mc_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({mc_if_ack, mc_mem_ack, mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata, mc_if_data, mc_mem_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {mc_if_ack, mc_mem_ack, mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata, mc_if_data, mc_mem_data});
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (mc_ram_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset en got=%b want=0", mc_ram_en);
        end
    endtask

    task automatic test_if_read();
        int n0;
        int a0;
        @(negedge clock);
        ram_lat = 2;
        ram_mem[32'h40] = 32'h8C22_0004;
        n0 = cyc;
        a0 = if_acks;
        do_if(32'h40, 32'h8C22_0004);
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (g_cyc[$] !== n0 + 1) begin errors++; $display("FAIL if_en_rise got=%0d want=%0d", g_cyc[$], n0 + 1); end
        checks++;
        if (g_we[$] !== 1'b0 || g_addr[$] !== 32'h40) begin
            errors++; $display("FAIL if_ram_cmd got we=%b addr=%h want we=0 addr=00000040", g_we[$], g_addr[$]);
        end
        checks++;
        if (last_run !== 2) begin errors++; $display("FAIL if_en_cycles got=%0d want=2", last_run); end
        checks++;
        if (last_if_ack !== n0 + 3) begin errors++; $display("FAIL if_ack_cycle got=%0d want=%0d", last_if_ack, n0 + 3); end
        checks++;
        if (if_acks - a0 !== 1) begin errors++; $display("FAIL if_ack_count got=%0d want=1", if_acks - a0); end
        checks++;
        if (mc_if_data !== 32'h8C22_0004) begin errors++; $display("FAIL if_data_held got=%h want=8c220004", mc_if_data); end
    endtask

    task automatic test_mem_write();
        @(negedge clock);
        ram_lat = 2;
        ram_mem[32'h200] = 32'h1234_5678;
        do_mem(1'b0, 32'h200, 32'h0, 32'h1234_5678);
        @(negedge clock);
        do_mem(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        #1;
        checks++;
        if (g_we[$] !== 1'b1 || g_addr[$] !== 32'h100 || g_wdata[$] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mem_write_cmd got we=%b addr=%h wdata=%h want we=1 addr=00000100 wdata=deadbeef",
                     g_we[$], g_addr[$], g_wdata[$]);
        end
        checks++;
        if (mc_mem_data !== 32'h1234_5678) begin errors++; $display("FAIL mem_data_kept got=%h want=12345678", mc_mem_data); end
        checks++;
        if (!ram_mem.exists(32'h100) || ram_mem[32'h100] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_written got=missing_or_wrong want=deadbeef");
        end
        @(negedge clock);
        do_mem(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_both();
        int n0;
        int gi;
        @(negedge clock);
        ram_lat = 1;
        n0 = cyc;
        gi = g_addr.size();
        fork
            do_mem(1'b0, 32'h300, 32'h0, pat(32'h300));
            do_if(32'h80, pat(32'h80));
        join
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (g_addr[gi] !== 32'h300 || g_addr[gi+1] !== 32'h80) begin
            errors++; $display("FAIL both_order got=%h,%h want=00000300,00000080", g_addr[gi], g_addr[gi+1]);
        end
        checks++;
        if (last_mem_ack !== n0 + 2) begin errors++; $display("FAIL both_mem_ack got=%0d want=%0d", last_mem_ack, n0 + 2); end
        checks++;
        if (g_cyc[gi+1] !== last_mem_ack + 1) begin
            errors++; $display("FAIL both_if_en_rise got=%0d want=%0d", g_cyc[gi+1], last_mem_ack + 1);
        end
    endtask

    task automatic test_starve();
        logic won_if;
        int   n;
        ram_lat = 1;
        for (int r = 0; r < SMAX + 2; r++) begin
            @(negedge clock);
            if_mc_addr  = 32'hC0;
            mem_mc_addr = 32'h400;
            mem_mc_rw   = 1'b0;
            if_mc_req   = 1'b1;
            mem_mc_req  = 1'b1;
            @(negedge clock);
            n = 0;
            if (mc_ram_en === 1'b1 && mc_ram_addr === 32'h400) begin
                won_if = 1'b0;
                if_mc_req = 1'b0;
                exp_mem_q.push_back({1'b0, pat(32'h400)});
                while (mc_mem_ack !== 1'b1 && n < 20) begin @(negedge clock); n++; end
                mem_mc_req = 1'b0;
            end else begin
                won_if = 1'b1;
                mem_mc_req = 1'b0;
                exp_if_q.push_back(pat(32'hC0));
                while (mc_if_ack !== 1'b1 && n < 20) begin @(negedge clock); n++; end
                if_mc_req = 1'b0;
            end
            checks++;
            if (won_if !== (r == SMAX) || n >= 20) begin
                errors++;
                $display("FAIL starve_round%0d got if_won=%b want=%b", r, won_if, (r == SMAX));
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        @(negedge clock);
        ram_lat = 6;
        a0 = mem_acks;
        mem_mc_rw    = 1'b1;
        mem_mc_addr  = 32'h500;
        mem_mc_wdata = 32'hCAFE_F00D;
        mem_mc_req   = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (mc_ram_en !== 1'b1 || mc_ram_we !== 1'b1) begin
            errors++; $display("FAIL mid_busy got en=%b we=%b want en=1 we=1", mc_ram_en, mc_ram_we);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mc_if_ack, mc_mem_ack, mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata, mc_if_data, mc_mem_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h want=0",
                     {mc_if_ack, mc_mem_ack, mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata, mc_if_data, mc_mem_data});
        end
        mem_mc_req = 1'b0;
        held_mem   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (mem_acks !== a0 || ram_mem.exists(32'h500)) begin
            errors++; $display("FAIL mid_abandoned got acks=%0d want=%0d", mem_acks - a0, 0);
        end
        ram_lat = 2;
        do_mem(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back();
        int            n0;
        int            n;
        int            a0;
        int            b0;
        int            ack_cyc[3];
        logic [AW-1:0] addrs[3];
        addrs[0] = 32'h1000;
        addrs[1] = 32'h1004;
        addrs[2] = 32'h1008;
        @(negedge clock);
        ram_lat = 1;
        n0 = cyc;
        for (int k = 0; k < 3; k++) exp_if_q.push_back(pat(addrs[k]));
        if_mc_addr = addrs[0];
        if_mc_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clock); n++; end while (mc_if_ack !== 1'b1 && n < 20);
            ack_cyc[k] = cyc;
            if (k < 2) if_mc_addr = addrs[k+1];
            else if_mc_req = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ack_cyc[k] !== n0 + 2 + 3 * k) begin
                errors++; $display("FAIL b2b_ack%0d got=%0d want=%0d", k, ack_cyc[k], n0 + 2 + 3 * k);
            end
        end
        @(negedge clock);
        a0 = if_acks;
        b0 = mem_acks;
        stray = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (if_acks !== a0 || mem_acks !== b0 || mc_ram_en !== 1'b0) begin
            errors++; $display("FAIL stray_ready got acks=%0d en=%b want acks=0 en=0", (if_acks - a0) + (mem_acks - b0), mc_ram_en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_both();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clock);
        checks++;
        if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got if=%0d mem=%0d want 0", exp_if_q.size(), exp_mem_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_controller.md
# mem_controller

Single-ported main-memory controller and arbiter for the five-stage Mips pipeline. Shares one external RAM port between the Fetch instruction port (read-only) and the Memory-stage data port (read/write). Uses a req/ack handshake with each requester and a start/ready handshake with the RAM. Data port has fixed priority, bounded by a starvation limit so Fetch always makes progress.

## Interface
- ADDR_W, 32, address width for both requesters and the RAM
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data-port grants with the instruction port waiting before the instruction port is forced to win (1..15)

- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all state
- if_mc_req  in  1  instruction read request; held until mc_if_ack
- if_mc_addr  in  ADDR_W  instruction address, stable while if_mc_req
- mc_if_ack  out  1  one-cycle pulse: instruction read complete
- mc_if_data  out  DATA_W  instruction word, valid while mc_if_ack and held until the next instruction ack
- mem_mc_req  in  1  data request; held until mc_mem_ack
- mem_mc_rw  in  1  1 = write, 0 = read; stable while mem_mc_req
- mem_mc_addr  in  ADDR_W  data address
- mem_mc_wdata  in  DATA_W  write data
- mc_mem_ack  out  1  one-cycle pulse: data access complete
- mc_mem_data  out  DATA_W  read data, valid while mc_mem_ack (reads only) and held afterwards
- mc_ram_en  out  1  RAM access in progress
- mc_ram_we  out  1  RAM write strobe, qualified by mc_ram_en
- mc_ram_addr  out  ADDR_W  RAM address
- mc_ram_wdata  out  DATA_W  RAM write data
- ram_mc_rdata  in  DATA_W  RAM read data, valid with ram_mc_ready
- ram_mc_ready  in  1  one-cycle pulse: RAM access finished

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- IDLE arbitration considers only requesters not acked in the current cycle:
  - mem_mc_req only → BUSY_MEM.
  - if_mc_req only → BUSY_IF.
  - Both requesting → BUSY_MEM, unless starve_cnt == STARVE_MAX, in which case → BUSY_IF.
  - Neither → stay in IDLE.
- On the grant transition, register the RAM outputs from the winner's signals:
  - mc_ram_en = 1.
  - mc_ram_we = mem_mc_rw for the data port, 0 for the instruction port.
  - Capture the winner's address and wdata.
- BUSY_x: hold all mc_ram_* outputs constant until ram_mc_ready.
- On ram_mc_ready:
  - Next cycle: mc_ram_en = 0 and mc_ram_we = 0; FSM → IDLE.
  - Pulse the matching ack for one cycle.
  - On reads, latch ram_mc_rdata into that port's data register.
  - A write ack leaves mc_mem_data unchanged.
- starve_cnt (4 bits):
  - Increments on each data-port grant made while if_mc_req is high.
  - Clears on any instruction-port grant.
  - Clears on a data-port grant made while if_mc_req is low.
  - Saturates at STARVE_MAX.
- ram_mc_ready received in IDLE is ignored.
- A request dropped before its ack is a protocol violation. The access still completes, and the ack is still pulsed.

## Timing
- Reset values: FSM = IDLE; starve_cnt = 0; every output = 0, including mc_if_data, mc_mem_data and mc_ram_addr.
- Latency, with request high in cycle N and RAM ready in cycle R:
  - mc_ram_en rises in N+1.
  - Ack is in R+1.
  - Minimum, with a 1-cycle RAM (R = N+1): ack in N+2.
- The ack cycle is an IDLE cycle, and the acked requester's req is masked in it. A different waiting requester is granted in that same cycle, so its mc_ram_en rises in R+2.
- The same requester re-requesting is granted no earlier than R+2, so its mc_ram_en rises in R+3.
- Reset asserted mid-access: immediate return to reset values. No ack is issued, and the in-flight RAM access is abandoned (mc_ram_en drops asynchronously).
- ram_mc_ready in the same cycle mc_ram_en rises is valid. The RAM may complete combinationally, and the ack follows next cycle.

## Test plan
- After reset release, drive if_mc_req with if_mc_addr=0x00000040 and a RAM returning 0x8C220004 with 2-cycle ready. Required: mc_ram_en high for 2 cycles with we=0; mc_if_ack pulses once; mc_if_data=0x8C220004 and stays held.
- Data write: mem_mc_rw=1, mem_mc_addr=0x100, mem_mc_wdata=0xDEADBEEF. Required: mc_ram_we=1 with matching addr/wdata; mc_mem_ack pulses; mc_mem_data keeps its previous value.
- Both requesters asserted in the same cycle. Required: data port granted first; the instruction grant occurs in the data ack cycle, so its mc_ram_en rises 1 cycle after the data ack.
- Starvation with STARVE_MAX=4: hold if_mc_req high and re-assert mem_mc_req continuously. Required: exactly 4 data grants, then the instruction grant, then data resumes.
- Reset driven low in the middle of BUSY_MEM. Required: all outputs read 0 immediately; no mc_mem_ack; after release, a fresh request completes normally.
- Back-to-back instruction reads with a 1-cycle RAM. Required: acks spaced every 3 cycles (for example N+2, N+5); a stray ram_mc_ready pulse in IDLE produces no ack.
